// File: rtl/lcd_pkg.sv
`timescale 1ns/1ps
// Shared definitions for the HD44780-class text controller: command bytes,
// DDRAM row bases and the sequencer/byte-writer state encodings.
package lcd_pkg;

    localparam logic [7:0] CMD_FUNC_8B2L = 8'h38;
    localparam logic [7:0] CMD_DISP_ON   = 8'h0C;
    localparam logic [7:0] CMD_CLEAR     = 8'h01;
    localparam logic [7:0] CMD_ENTRY_INC = 8'h06;
    localparam logic [7:0] CMD_SET_DDRAM = 8'h80;

    localparam int INIT_LEN = 5;

    typedef enum logic [2:0] {
        ST_PWR_WAIT,
        ST_INIT,
        ST_LATCH,
        ST_REFRESH,
        ST_DONE,
        ST_IDLE
    } top_state_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_SETUP,
        W_STROBE,
        W_HOLD
    } wr_state_t;

    function automatic logic [7:0] init_cmd(input logic [2:0] idx);
        case (idx)
            3'd0, 3'd1: init_cmd = CMD_FUNC_8B2L;
            3'd2:       init_cmd = CMD_DISP_ON;
            3'd3:       init_cmd = CMD_CLEAR;
            default:    init_cmd = CMD_ENTRY_INC;
        endcase
    endfunction

    function automatic logic [7:0] row_base(input logic [1:0] row);
        case (row)
            2'd0:    row_base = 8'h00;
            2'd1:    row_base = 8'h40;
            2'd2:    row_base = 8'h14;
            default: row_base = 8'h54;
        endcase
    endfunction

    function automatic int cnt_width(input int a, input int b);
        return $clog2(((a > b) ? a : b) + 1);
    endfunction

endpackage

// File: rtl/lcd_text_ctrl_writer.sv
`timescale 1ns/1ps
// One LCD bus transfer: SETUP (1 cycle), STROBE (EN_CYC), HOLD (CMD_CYC or
// CLR_CYC after a clear command). done marks the last HOLD cycle.
module lcd_byte_writer
    import lcd_pkg::*;
#(
    parameter int EN_CYC  = 12,
    parameter int CMD_CYC = 2000,
    parameter int CLR_CYC = 82000,
    parameter int CNT_W   = 17
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       rs,
    input  logic [7:0] data,
    output logic       ready,
    output logic       done,
    output logic [7:0] lcd_data,
    output logic       lcd_rs,
    output logic       lcd_en
);

    wr_state_t        state, next_state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] hold_last;
    logic             is_clear;

    always_comb begin
        hold_last  = is_clear ? CNT_W'(CLR_CYC - 1) : CNT_W'(CMD_CYC - 1);
        done       = (state == W_HOLD) && (cnt == hold_last);
        ready      = (state == W_IDLE) || done;
        next_state = state;
        case (state)
            W_IDLE:   if (start) next_state = W_SETUP;
            W_SETUP:  next_state = W_STROBE;
            W_STROBE: if (cnt == CNT_W'(EN_CYC - 1)) next_state = W_HOLD;
            W_HOLD:   if (done) next_state = start ? W_SETUP : W_IDLE;
            default:  next_state = W_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments; lcd_en is registered
    // from next_state so it is glitch-free and the async reset drops it at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= W_IDLE;
            cnt      <= '0;
            is_clear <= 1'b0;
            lcd_data <= '0;
            lcd_rs   <= 1'b0;
            lcd_en   <= 1'b0;
        end else begin
            state  <= next_state;
            cnt    <= (next_state == state && state != W_IDLE) ? cnt + 1'b1 : '0;
            lcd_en <= (next_state == W_STROBE);
            if (ready && start) begin
                lcd_data <= data;
                lcd_rs   <= rs;
                is_clear <= !rs && (data == CMD_CLEAR);
            end
        end
    end

endmodule

// File: rtl/lcd_text_ctrl.sv
`timescale 1ns/1ps
// Character-LCD controller: power-up wait, init command list, then frame
// redraws of a ROWS x COLS text snapshot with per-row DDRAM addressing.
module lcd_text_ctrl
    import lcd_pkg::*;
#(
    parameter int COLS      = 16,
    parameter int ROWS      = 2,
    parameter int PWRUP_CYC = 750000,
    parameter int EN_CYC    = 12,
    parameter int CMD_CYC   = 2000,
    parameter int CLR_CYC   = 82000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [ROWS*COLS*8-1:0] data_in,
    input  logic                   update,
    output logic                   busy,
    output logic [7:0]             lcd_data,
    output logic                   lcd_rs,
    output logic                   lcd_rw,
    output logic                   lcd_en
);

    localparam int CNT_W = cnt_width(PWRUP_CYC, CLR_CYC);
    localparam int NBITS = ROWS * COLS * 8;

    top_state_t       state, next_state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       init_idx;
    logic [1:0]       row;
    logic [5:0]       col;
    logic             addr_phase;
    logic [NBITS-1:0] snapshot;
    logic             pending;
    logic             last_char;

    logic             wr_start, wr_rs, wr_ready, wr_done;
    logic [7:0]       wr_data;

    lcd_byte_writer #(
        .EN_CYC  (EN_CYC),
        .CMD_CYC (CMD_CYC),
        .CLR_CYC (CLR_CYC),
        .CNT_W   (CNT_W)
    ) u_writer (
        .clk      (clk),
        .rst      (rst),
        .start    (wr_start),
        .rs       (wr_rs),
        .data     (wr_data),
        .ready    (wr_ready),
        .done     (wr_done),
        .lcd_data (lcd_data),
        .lcd_rs   (lcd_rs),
        .lcd_en   (lcd_en)
    );

    assign busy   = (state != ST_IDLE);
    assign lcd_rw = 1'b0;

    // NOTE: every signal written here gets a default first, so no latch is inferred.
    always_comb begin
        next_state = state;
        wr_start   = 1'b0;
        wr_rs      = 1'b0;
        wr_data    = '0;
        last_char  = (row == 2'(ROWS - 1)) && (col == 6'(COLS - 1));
        case (state)
            ST_PWR_WAIT: if (cnt == CNT_W'(PWRUP_CYC - 1)) next_state = ST_INIT;
            ST_INIT: begin
                if (wr_ready) begin
                    wr_start = 1'b1;
                    wr_data  = init_cmd(init_idx);
                    if (init_idx == 3'(INIT_LEN - 1)) next_state = ST_LATCH;
                end
            end
            ST_LATCH: next_state = ST_REFRESH;
            ST_REFRESH: begin
                if (wr_ready) begin
                    wr_start = 1'b1;
                    if (addr_phase) begin
                        wr_data = CMD_SET_DDRAM | row_base(row);
                    end else begin
                        wr_rs   = 1'b1;
                        wr_data = snapshot[NBITS-1 -: 8];
                        if (last_char) next_state = ST_DONE;
                    end
                end
            end
            // Wait for the last byte's hold so busy covers the whole frame.
            ST_DONE: if (wr_done) next_state = (pending || update) ? ST_LATCH : ST_IDLE;
            ST_IDLE: if (update) next_state = ST_LATCH;
            default: next_state = ST_PWR_WAIT;
        endcase
    end

    // NOTE: snapshot is reset because its cleared value is part of the block's reset state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_PWR_WAIT;
            cnt        <= '0;
            init_idx   <= '0;
            row        <= '0;
            col        <= '0;
            addr_phase <= 1'b0;
            snapshot   <= '0;
            pending    <= 1'b0;
        end else begin
            state <= next_state;
            cnt   <= (state == ST_PWR_WAIT && next_state == ST_PWR_WAIT) ? cnt + 1'b1 : '0;

            if (state == ST_INIT && wr_start) init_idx <= init_idx + 1'b1;

            if (state == ST_LATCH) begin
                snapshot   <= data_in;
                row        <= '0;
                col        <= '0;
                addr_phase <= 1'b1;
            end else if (state == ST_REFRESH && wr_start) begin
                if (addr_phase) begin
                    addr_phase <= 1'b0;
                end else begin
                    snapshot <= snapshot << 8;
                    if (col == 6'(COLS - 1)) begin
                        col        <= '0;
                        row        <= row + 1'b1;
                        addr_phase <= 1'b1;
                    end else begin
                        col <= col + 1'b1;
                    end
                end
            end

            // A request seen during the latch cycle is served by that latch.
            if (state == ST_LATCH) pending <= 1'b0;
            else if (update && state != ST_IDLE) pending <= 1'b1;
        end
    end

endmodule

// File: tb/tb_lcd_text_ctrl.sv
`timescale 1ns/1ps
// Self-checking bench for lcd_text_ctrl: scoreboard of expected bus bytes
// (rs, data, spacing from the previous byte) compared at each lcd_en rise.
module tb_lcd_text_ctrl;

    localparam int PWRUP = 20;
    localparam int EN    = 2;

    logic        clk = 1'b0;
    logic        rst, rst_b, update, update_b;
    logic [63:0] data_in, data_in_b;
    logic        busy, lcd_rs, lcd_rw, lcd_en;
    logic [7:0]  lcd_data;
    logic        busy_b, lcd_rs_b, lcd_rw_b, lcd_en_b;
    logic [7:0]  lcd_data_b;

    always #5 clk = ~clk;

    lcd_text_ctrl #(
        .COLS(4), .ROWS(2), .PWRUP_CYC(PWRUP), .EN_CYC(EN), .CMD_CYC(4), .CLR_CYC(8)
    ) dut_a (
        .clk(clk), .rst(rst), .data_in(data_in), .update(update), .busy(busy),
        .lcd_data(lcd_data), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_en(lcd_en)
    );

    lcd_text_ctrl #(
        .COLS(2), .ROWS(4), .PWRUP_CYC(PWRUP), .EN_CYC(EN), .CMD_CYC(4), .CLR_CYC(8)
    ) dut_b (
        .clk(clk), .rst(rst_b), .data_in(data_in_b), .update(update_b), .busy(busy_b),
        .lcd_data(lcd_data_b), .lcd_rs(lcd_rs_b), .lcd_rw(lcd_rw_b), .lcd_en(lcd_en_b)
    );

    typedef struct {
        logic       rs;
        logic [7:0] data;
        int         gap;   // cycles since previous lcd_en rise, 0 = unchecked
    } exp_t;

    typedef struct {
        logic [63:0] text;
        int          exp_bytes;
    } vec_t;

    exp_t exp_a[$];
    exp_t exp_b[$];
    exp_t ea, eb;
    int   n_checks = 0;
    int   n_pass = 0;
    int   cyc = 0;
    int   last_rise_a = -1;
    int   hi_a = 0;
    int   bytes_a = 0;
    logic prev_en_a = 1'b0;
    logic prev_en_b = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic void push_exp(input bit sel, input logic rs, input logic [7:0] d, input int gap);
        exp_t e;
        e.rs   = rs;
        e.data = d;
        e.gap  = gap;
        if (sel) exp_b.push_back(e);
        else exp_a.push_back(e);
    endfunction

    function automatic void push_frame(input bit sel, input int rows, input int cols,
                                       input logic [63:0] text, input int first_gap);
        logic [7:0] base [4];
        base[0] = 8'h00; base[1] = 8'h40; base[2] = 8'h14; base[3] = 8'h54;
        for (int r = 0; r < rows; r++) begin
            push_exp(sel, 1'b0, 8'h80 | base[r], (r == 0) ? first_gap : 7);
            for (int c = 0; c < cols; c++)
                push_exp(sel, 1'b1, text[(rows*cols-1-(r*cols+c))*8 +: 8], 7);
        end
    endfunction

    function automatic void push_init(input bit sel, input int rows, input int cols, input logic [63:0] text);
        push_exp(sel, 1'b0, 8'h38, 0);
        push_exp(sel, 1'b0, 8'h38, 7);
        push_exp(sel, 1'b0, 8'h0C, 7);
        push_exp(sel, 1'b0, 8'h01, 7);
        push_exp(sel, 1'b0, 8'h06, 11);
        push_frame(sel, rows, cols, text, 7);
    endfunction

    // Monitor A: byte content, spacing, strobe width, lcd_rw.
    initial forever begin
        @(negedge clk);
        if (rst) begin
            prev_en_a   = 1'b0;
            hi_a        = 0;
            last_rise_a = -1;
        end else begin
            if (lcd_en && !prev_en_a) begin
                hi_a = 1;
                bytes_a++;
                check("rw_a", 32'(lcd_rw), 32'd0);
                if (exp_a.size() == 0) begin
                    check("unexpected_byte_a", 32'({lcd_rs, lcd_data}), 32'hFFFF_FFFF);
                end else begin
                    ea = exp_a.pop_front();
                    check("byte_a", 32'({lcd_rs, lcd_data}), 32'({ea.rs, ea.data}));
                    if (ea.gap != 0 && last_rise_a >= 0) check("gap_a", cyc - last_rise_a, ea.gap);
                end
                last_rise_a = cyc;
            end else if (lcd_en) begin
                hi_a++;
            end else if (prev_en_a) begin
                check("en_width_a", hi_a, EN);
            end
            prev_en_a = lcd_en;
        end
    end

    // Monitor B: 4-row addressing.
    initial forever begin
        @(negedge clk);
        if (rst_b) begin
            prev_en_b = 1'b0;
        end else begin
            if (lcd_en_b && !prev_en_b) begin
                check("rw_b", 32'(lcd_rw_b), 32'd0);
                if (exp_b.size() == 0) begin
                    check("unexpected_byte_b", 32'({lcd_rs_b, lcd_data_b}), 32'hFFFF_FFFF);
                end else begin
                    eb = exp_b.pop_front();
                    check("byte_b", 32'({lcd_rs_b, lcd_data_b}), 32'({eb.rs, eb.data}));
                end
            end
            prev_en_b = lcd_en_b;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    task automatic wait_idle_a(input int limit);
        int n = 0;
        while (busy !== 1'b0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (busy !== 1'b0) check("timeout_idle_a", 32'(busy), 32'd0);
    endtask

    task automatic pwr_wait_a();
        for (int i = 0; i < PWRUP; i++) begin
            @(negedge clk);
            check("pwr_wait_en_busy", 32'({lcd_en, busy}), 32'h1);
        end
    endtask

    task automatic pulse_update();
        update = 1'b1;
        @(negedge clk);
        update = 1'b0;
    endtask

    initial begin
        vec_t vecs[3];
        int   n;
        int   b0;

        vecs[0] = '{"WXYZ1234", 10};
        vecs[1] = '{{8'h01, 8'h00, 8'hFF, 8'h80, "abcd"}, 10};
        vecs[2] = '{"HD44780!", 10};

        rst = 1'b1; rst_b = 1'b1; update = 1'b0; update_b = 1'b0;
        data_in = "ABCDEFGH"; data_in_b = "PQRSTUVW";
        repeat (3) @(negedge clk);
        check("reset_a", 32'({lcd_data, lcd_rs, lcd_rw, lcd_en, busy}), 32'h001);
        check("reset_b", 32'({lcd_data_b, lcd_rs_b, lcd_rw_b, lcd_en_b, busy_b}), 32'h001);

        // Power-up, init and automatic first frame on both instances.
        push_init(1'b0, 2, 4, data_in);
        push_init(1'b1, 4, 2, data_in_b);
        rst = 1'b0; rst_b = 1'b0;
        pwr_wait_a();
        wait_idle_a(1000);
        check("busy_fall_first", cyc - last_rise_a, 6);
        check("first_frame_done_a", exp_a.size(), 0);
        n = 0;
        while (busy_b !== 1'b0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("idle_b", 32'(busy_b), 32'd0);
        check("frame_done_b", exp_b.size(), 0);

        // Table-driven redraws from IDLE.
        foreach (vecs[i]) begin
            check("idle_before_update", 32'(busy), 32'd0);
            data_in = vecs[i].text;
            b0 = bytes_a;
            push_frame(1'b0, 2, 4, vecs[i].text, 0);
            pulse_update();
            check("busy_after_update", 32'(busy), 32'd1);
            wait_idle_a(400);
            check("busy_fall", cyc - last_rise_a, 6);
            check("frame_bytes", bytes_a - b0, vecs[i].exp_bytes);
            check("frame_queue_empty", exp_a.size(), 0);
        end

        // Update held across the latch cycle is absorbed: one frame only.
        data_in = "ONCEONLY";
        push_frame(1'b0, 2, 4, data_in, 0);
        update = 1'b1;
        repeat (2) @(negedge clk);
        update = 1'b0;
        wait_idle_a(400);
        check("latch_absorb_queue", exp_a.size(), 0);
        repeat (20) @(negedge clk);
        check("latch_absorb_no_extra", 32'(busy), 32'd0);

        // Three updates mid-frame collapse into one extra frame with latest data.
        data_in = "FRAME#1!";
        push_frame(1'b0, 2, 4, data_in, 0);
        pulse_update();
        repeat (15) @(negedge clk);
        data_in = "SECOND!!";
        pulse_update();
        repeat (10) @(negedge clk);
        data_in = "THIRD!!!";
        pulse_update();
        repeat (5) @(negedge clk);
        data_in = "LATEST!!";
        pulse_update();
        push_frame(1'b0, 2, 4, data_in, 0);
        n = 0;
        while (exp_a.size() > 9 && n < 400) begin
            @(negedge clk);
            n++;
        end
        data_in = "garbage!";
        wait_idle_a(600);
        check("collapse_both_frames", exp_a.size(), 0);
        repeat (20) @(negedge clk);
        check("collapse_no_third", 32'(busy), 32'd0);

        // Reset during a data-byte strobe aborts and restarts the full init.
        data_in = "RESETME!";
        push_frame(1'b0, 2, 4, data_in, 0);
        pulse_update();
        n = 0;
        while (!(lcd_en === 1'b1 && lcd_rs === 1'b1) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("found_data_strobe", 32'(lcd_en & lcd_rs), 32'd1);
        #2 rst = 1'b1;
        #1 check("reset_async", 32'({lcd_data, lcd_rs, lcd_rw, lcd_en, busy}), 32'h001);
        exp_a.delete();
        repeat (2) @(negedge clk);
        push_init(1'b0, 2, 4, data_in);
        rst = 1'b0;
        pwr_wait_a();
        wait_idle_a(1000);
        check("reinit_busy_fall", cyc - last_rise_a, 6);
        check("reinit_queue_empty", exp_a.size(), 0);

        repeat (5) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
